dl_probe_scheduler: RTL and testbench

- Sequencing controller for the cosim deadlock-detection network.
- Watches per-process blocked flags and debounces them until stable. Picks one process round-robin as probe origin, launches the token probe, then either confirms a deadlock or clears the tokens and moves to the next candidate.
- Sits between the per-process detect units and the report logic, and drives their origin, dl_detect and token_clear inputs.

---
 rtl/dl_probe_scheduler.sv | 175 +++++++++++++++++
 tb/tb_dl_probe_scheduler.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/dl_probe_scheduler.sv
// Deadlock probe sequencer: debounces blocked flags, launches a token probe from a
// round-robin origin, then confirms a deadlock or clears tokens and moves on.
module dl_probe_scheduler #(
    parameter int PROC_NUM      = 3,
    parameter int IDX_W         = 2,
    parameter int STABLE_CYCLES = 16,
    parameter int PROBE_TIMEOUT = 64
) (
    input  logic                dl_clock,
    input  logic                dl_reset,
    input  logic                all_finish,
    input  logic [PROC_NUM-1:0] dl_in_vec,
    input  logic [PROC_NUM-1:0] token_return_vec,
    output logic [PROC_NUM-1:0] origin,
    output logic                dl_detect_out,
    output logic                token_clear,
    output logic                deadlock_found,
    output logic [IDX_W-1:0]    deadlock_proc,
    output logic                busy
);

    localparam int SC_W = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam int PT_W = $clog2(PROBE_TIMEOUT);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_PROBE,
        ST_CLEAR,
        ST_FOUND
    } state_t;

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]    sel_q, sel_d;
    logic [SC_W-1:0]     settle_cnt_q, settle_cnt_d;
    logic [PT_W-1:0]     probe_cnt_q, probe_cnt_d;
    logic [PROC_NUM-1:0] cand_prev_q, cand_prev_d;
    logic [PROC_NUM-1:0] origin_q, origin_d;
    logic                dl_detect_q, dl_detect_d;
    logic                token_clear_q, token_clear_d;
    logic                deadlock_found_q, deadlock_found_d;
    logic [IDX_W-1:0]    deadlock_proc_q, deadlock_proc_d;
    logic                busy_q, busy_d;

    logic [PROC_NUM-1:0] cand;
    logic [IDX_W-1:0]    rr_sel;
    logic                rr_hit;

    assign cand = dl_in_vec & ~{PROC_NUM{all_finish}};

    // Two passes: indices at or above rr_ptr first, then the wrapped-around low indices.
    always_comb begin
        rr_hit = 1'b0;
        rr_sel = '0;
        for (int unsigned j = 0; j < PROC_NUM; j++) begin
            if (!rr_hit && cand[j] && (IDX_W'(j) >= rr_ptr_q)) begin
                rr_hit = 1'b1;
                rr_sel = IDX_W'(j);
            end
        end
        for (int unsigned j = 0; j < PROC_NUM; j++) begin
            if (!rr_hit && cand[j]) begin
                rr_hit = 1'b1;
                rr_sel = IDX_W'(j);
            end
        end
    end

    always_comb begin
        state_d          = state_q;
        rr_ptr_d         = rr_ptr_q;
        sel_d            = sel_q;
        settle_cnt_d     = settle_cnt_q;
        probe_cnt_d      = probe_cnt_q;
        cand_prev_d      = cand_prev_q;
        origin_d         = origin_q;
        dl_detect_d      = dl_detect_q;
        token_clear_d    = 1'b0;
        deadlock_found_d = deadlock_found_q;
        deadlock_proc_d  = deadlock_proc_q;

        case (state_q)
            ST_IDLE: begin
                if (cand != '0) begin
                    state_d      = ST_SETTLE;
                    settle_cnt_d = '0;
                    cand_prev_d  = cand;
                end
            end
            ST_SETTLE: begin
                if (cand == '0) begin
                    state_d = ST_IDLE;
                end else if (cand != cand_prev_q) begin
                    settle_cnt_d = '0;
                    cand_prev_d  = cand;
                end else if (settle_cnt_q == SC_W'(STABLE_CYCLES - 1)) begin
                    state_d     = ST_PROBE;
                    sel_d       = rr_sel;
                    origin_d    = PROC_NUM'(1) << rr_sel;
                    dl_detect_d = 1'b1;
                    probe_cnt_d = '0;
                end else begin
                    settle_cnt_d = settle_cnt_q + 1'b1;
                end
            end
            // origin_q is one-hot on sel_q here, so masking replaces a variable index.
            ST_PROBE: begin
                if ((token_return_vec & origin_q) != '0) begin
                    state_d          = ST_FOUND;
                    deadlock_found_d = 1'b1;
                    deadlock_proc_d  = sel_q;
                end else if (all_finish || ((dl_in_vec & origin_q) == '0) ||
                             (probe_cnt_q == PT_W'(PROBE_TIMEOUT - 1))) begin
                    state_d       = ST_CLEAR;
                    token_clear_d = 1'b1;
                    origin_d      = '0;
                    dl_detect_d   = 1'b0;
                    rr_ptr_d      = (sel_q == IDX_W'(PROC_NUM - 1)) ? '0 : sel_q + 1'b1;
                end else begin
                    probe_cnt_d = probe_cnt_q + 1'b1;
                end
            end
            ST_CLEAR: begin
                state_d = ST_IDLE;
            end
            ST_FOUND: begin
                state_d = ST_FOUND;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge dl_clock or negedge dl_reset) begin
        if (!dl_reset) begin
            state_q          <= ST_IDLE;
            rr_ptr_q         <= '0;
            sel_q            <= '0;
            settle_cnt_q     <= '0;
            probe_cnt_q      <= '0;
            cand_prev_q      <= '0;
            origin_q         <= '0;
            dl_detect_q      <= 1'b0;
            token_clear_q    <= 1'b0;
            deadlock_found_q <= 1'b0;
            deadlock_proc_q  <= '0;
            busy_q           <= 1'b0;
        end else begin
            state_q          <= state_d;
            rr_ptr_q         <= rr_ptr_d;
            sel_q            <= sel_d;
            settle_cnt_q     <= settle_cnt_d;
            probe_cnt_q      <= probe_cnt_d;
            cand_prev_q      <= cand_prev_d;
            origin_q         <= origin_d;
            dl_detect_q      <= dl_detect_d;
            token_clear_q    <= token_clear_d;
            deadlock_found_q <= deadlock_found_d;
            deadlock_proc_q  <= deadlock_proc_d;
            busy_q           <= busy_d;
        end
    end

    assign origin         = origin_q;
    assign dl_detect_out  = dl_detect_q;
    assign token_clear    = token_clear_q;
    assign deadlock_found = deadlock_found_q;
    assign deadlock_proc  = deadlock_proc_q;
    assign busy           = busy_q;

endmodule

// File: tb/tb_dl_probe_scheduler.sv
// Directed bench for dl_probe_scheduler with STABLE_CYCLES=4, PROBE_TIMEOUT=8.
module tb_dl_probe_scheduler;

    logic       dl_clock = 1'b0;
    logic       dl_reset = 1'b0;
    logic       all_finish = 1'b0;
    logic [2:0] dl_in_vec = '0;
    logic [2:0] token_return_vec = '0;
    logic [2:0] origin;
    logic       dl_detect_out;
    logic       token_clear;
    logic       deadlock_found;
    logic [1:0] deadlock_proc;
    logic       busy;

    int n_checks = 0;
    int n_errors = 0;
    int tc_cnt   = 0;
    int tc_base  = 0;

    dl_probe_scheduler #(
        .PROC_NUM     (3),
        .IDX_W        (2),
        .STABLE_CYCLES(4),
        .PROBE_TIMEOUT(8)
    ) dut (
        .dl_clock        (dl_clock),
        .dl_reset        (dl_reset),
        .all_finish      (all_finish),
        .dl_in_vec       (dl_in_vec),
        .token_return_vec(token_return_vec),
        .origin          (origin),
        .dl_detect_out   (dl_detect_out),
        .token_clear     (token_clear),
        .deadlock_found  (deadlock_found),
        .deadlock_proc   (deadlock_proc),
        .busy            (busy)
    );

    always #5 dl_clock = ~dl_clock;

    always @(negedge dl_clock) begin
        if (token_clear) tc_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge dl_clock);
        #1;
    endtask

    task automatic apply_reset();
        dl_reset         = 1'b0;
        all_finish       = 1'b0;
        dl_in_vec        = '0;
        token_return_vec = '0;
        step(2);
        dl_reset = 1'b1;
    endtask

    initial begin
        // Reset state
        step(2);
        check("rst_origin", origin, 3'b000);
        check("rst_detect", dl_detect_out, 1'b0);
        check("rst_tclear", token_clear, 1'b0);
        check("rst_found", deadlock_found, 1'b0);
        check("rst_proc", deadlock_proc, 2'd0);
        check("rst_busy", busy, 1'b0);
        dl_reset = 1'b1;

        // Confirmed deadlock on origin 0
        tc_base = tc_cnt;
        dl_in_vec = 3'b011;
        step(1);
        check("t1_busy_settle", busy, 1'b1);
        check("t1_origin_settle", origin, 3'b000);
        step(3);
        check("t1_origin_pre", origin, 3'b000);
        step(1);
        check("t1_origin_launch", origin, 3'b001);
        check("t1_detect_launch", dl_detect_out, 1'b1);
        step(4);
        check("t1_origin_probe", origin, 3'b001);
        token_return_vec = 3'b001;
        step(1);
        check("t1_found", deadlock_found, 1'b1);
        check("t1_proc", deadlock_proc, 2'd0);
        check("t1_origin_found", origin, 3'b001);
        dl_in_vec        = '0;
        token_return_vec = '0;
        all_finish       = 1'b1;
        step(6);
        check("t1_found_sticky", deadlock_found, 1'b1);
        check("t1_origin_held", origin, 3'b001);
        check("t1_detect_held", dl_detect_out, 1'b1);
        check("t1_busy_found", busy, 1'b1);
        check("t1_no_tclear", tc_cnt - tc_base, 0);

        // Timeout and round-robin
        apply_reset();
        tc_base = tc_cnt;
        dl_in_vec = 3'b011;
        step(5);
        check("t2_origin0", origin, 3'b001);
        step(7);
        check("t2_origin_last", origin, 3'b001);
        check("t2_tclear_last", token_clear, 1'b0);
        step(1);
        check("t2_tclear", token_clear, 1'b1);
        check("t2_origin_clear", origin, 3'b000);
        check("t2_detect_clear", dl_detect_out, 1'b0);
        check("t2_busy_clear", busy, 1'b1);
        step(1);
        check("t2_tclear_off", token_clear, 1'b0);
        check("t2_busy_idle", busy, 1'b0);
        step(5);
        check("t2_origin1", origin, 3'b010);
        step(8);
        check("t2_tclear2", token_clear, 1'b1);
        step(6);
        check("t2_origin_wrap", origin, 3'b001);
        check("t2_tclear_count", tc_cnt - tc_base, 2);

        // Asynchronous reset mid-probe
        #2;
        dl_reset  = 1'b0;
        dl_in_vec = 3'b100;
        #1;
        check("t6_origin_async", origin, 3'b000);
        check("t6_detect_async", dl_detect_out, 1'b0);
        check("t6_busy_async", busy, 1'b0);
        check("t6_tclear_async", token_clear, 1'b0);
        step(1);
        dl_reset = 1'b1;
        step(4);
        check("t6_origin_pre", origin, 3'b000);
        step(1);
        check("t6_origin_relaunch", origin, 3'b100);
        check("t6_tclear_count", tc_cnt - tc_base, 2);

        // Unstable candidates never launch
        apply_reset();
        for (int k = 0; k < 5; k++) begin
            dl_in_vec = (k % 2 == 1) ? 3'b100 : 3'b001;
            step(1);
            check("t3_origin_toggle_a", origin, 3'b000);
            step(1);
            check("t3_origin_toggle_b", origin, 3'b000);
        end
        check("t3_busy_settle", busy, 1'b1);
        dl_in_vec = 3'b100;
        step(4);
        check("t3_origin_pre", origin, 3'b000);
        step(1);
        check("t3_origin_launch", origin, 3'b100);

        // Origin unblocks mid-probe
        apply_reset();
        dl_in_vec = 3'b010;
        step(5);
        check("t4_origin1", origin, 3'b010);
        step(2);
        dl_in_vec = 3'b101;
        step(1);
        check("t4_tclear", token_clear, 1'b1);
        check("t4_origin_clear", origin, 3'b000);
        check("t4_detect_clear", dl_detect_out, 1'b0);
        check("t4_found", deadlock_found, 1'b0);
        step(1);
        check("t4_tclear_off", token_clear, 1'b0);
        step(5);
        check("t4_origin_rr2", origin, 3'b100);

        // all_finish during probe
        all_finish = 1'b1;
        step(1);
        check("t5_tclear", token_clear, 1'b1);
        check("t5_origin_clear", origin, 3'b000);
        step(1);
        check("t5_busy_idle", busy, 1'b0);
        step(10);
        check("t5_busy_masked", busy, 1'b0);
        check("t5_origin_masked", origin, 3'b000);
        all_finish = 1'b0;
        step(4);
        check("t5_origin_pre", origin, 3'b000);
        step(1);
        check("t5_origin_wrap", origin, 3'b001);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
